gate_drive_out: RTL and testbench
=================================

Name: gate_drive_out

Overview:
- Parametrised successor to the fixed two-bridge gate output stage. Drives CHANNELS complementary half-bridge gate pairs from per-channel phase commands, typically the PLL driver's out_A/out_B.
- Adds programmable dead-time insertion, a latched fault shutdown with explicit clear, and enable re-arm sequencing.
- Sits between the QCW PLL driver and the gate driver pins, in the 160 MHz system domain.

Parameters:
- CHANNELS, 2, number of half-bridge gate pairs.
- DT_WIDTH, 8, width of the dead_time input and of each per-channel dead-time counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  output enable. Low forces all gates off.
- phase_in  in  CHANNELS  commanded phase per channel: 1 = P side on, 0 = N side on. Synchronous to clk.
- dead_time  in  DT_WIDTH  dead interval in clk cycles. Sampled at the start of each dead interval.
- fault_in  in  1  synchronous fault request, e.g. OCD halt.
- fault_clear  in  1  single-cycle pulse that clears the fault latch.
- gate_p  out  CHANNELS  high-side gate drive, registered.
- gate_n  out  CHANNELS  low-side gate drive, registered.
- fault_latched  out  1  fault latch state.
- active  out  1  high while any channel is in P_ON or N_ON.

Behaviour:
- Reset (asynchronous): gate_p=0, gate_n=0, fault_latched=0, active=0, every channel FSM in OFF, armed=0.
- Definition: D = max(dead_time, 1). Neither side is ever driven without at least one cycle with both sides off.
- Per-channel FSM states: OFF, DEAD, P_ON, N_ON. Every gate output is a registered function of the state, so each transition takes effect at the clock edge that takes it.
- Arm logic:
  - armed is set on any edge with enable=0 and fault_latched=0.
  - armed is cleared when a fault latches.
  - Enable is only honoured while armed=1, so after a fault, enable must go low and then high again before the outputs run.
- OFF -> DEAD: on an edge with enable=1, armed=1, fault_latched=0. Counter loads D. Both sides stay off.
- DEAD:
  - Each edge decrements the counter.
  - If phase_in changes value during DEAD, the counter reloads D; the interval restarts.
  - At the edge where the counter equals 1 and phase_in is unchanged, go to P_ON if phase_in=1, else N_ON.
  - Result: both sides are off for exactly D cycles after the last phase change.
- P_ON / N_ON:
  - The selected side is driven high.
  - On an edge where phase_in differs from the driven side, go to DEAD and load D. The on-side falls at that same edge.
- Latency: a phase change at edge k gives the old side low after edge k and the new side high after edge k+D.
- Shutdown, highest priority:
  - fault_in=1 at any edge: every channel goes to OFF, all gates go low, fault_latched=1, armed=0. Takes effect at that edge.
  - enable=0 at any edge: every channel goes to OFF and all gates go low. fault_latched is unaffected.
- fault_clear:
  - fault_clear=1 with fault_in=0 clears fault_latched.
  - If fault_in and fault_clear are both high in the same cycle, the fault wins: the latch stays set.
- A dead_time change while in DEAD has no effect until the next reload.
- active = OR over channels of (state is P_ON or N_ON), registered together with the gates.
- Invariant, which the bench asserts every cycle: gate_p[i] and gate_n[i] are never both 1.

Test Plan:
- Reset check: assert reset mid-run with gates on. All outputs are 0 immediately, with no clock edge required.
- Dead time 16: enable with armed=1 and phase_in=2'b01. Channel 0 has gate_p high and channel 1 has gate_n high 16 cycles after the enable edge. Then toggle channel 0's phase: gate_p[0] falls at that edge, and gate_n[0] rises exactly 16 cycles later.
- dead_time=0: toggle phase. There is exactly one both-off cycle between sides.
- Glitch during DEAD: with dead_time=10, toggle phase, then toggle again after 4 cycles. Both gates stay off, and the side matching the final phase_in rises 10 cycles after the second toggle.
- Fault mid-run:
  - Pulse fault_in. All gates are 0 and fault_latched=1 at that edge, and active=0.
  - Asserting fault_clear together with fault_in leaves the latch set.
  - A later fault_clear with fault_in low clears the latch, but the gates stay off until enable goes 0 and then 1.
- Enable drop: deassert enable for 1 cycle while running. The gates are off at that edge. On re-enable, a full dead interval of dead_time cycles precedes any gate going high.

Source files
------------

// File: rtl/gate_drive_out_if.sv
// Bundle of the gate_drive_out control and gate signals.
// Direction convention: the master is the controller side (the PLL driver
// plus fault logic), which drives enable, phase, dead time and fault
// requests. The slave is gate_drive_out, which returns the gate drives,
// the fault latch and the debug view of its state.
interface gate_drive_out_if #(
    parameter int CHANNELS = 2,
    parameter int DT_WIDTH = 8
);
    logic                     enable;
    logic [CHANNELS-1:0]      phase_in;
    logic [DT_WIDTH-1:0]      dead_time;
    logic                     fault_in;
    logic                     fault_clear;
    logic [CHANNELS-1:0]      gate_p;
    logic [CHANNELS-1:0]      gate_n;
    logic                     fault_latched;
    logic                     active;
    // Debug view: per-channel FSM state and the arm flag.
    logic [CHANNELS-1:0][1:0] state_dbg;
    logic                     armed_dbg;

    modport master (
        output enable, phase_in, dead_time, fault_in, fault_clear,
        input  gate_p, gate_n, fault_latched, active, state_dbg, armed_dbg
    );

    modport slave (
        input  enable, phase_in, dead_time, fault_in, fault_clear,
        output gate_p, gate_n, fault_latched, active, state_dbg, armed_dbg
    );
endinterface

// File: rtl/gate_drive_out.sv
// Complementary half-bridge gate output stage, CHANNELS pairs.
// Each channel runs OFF -> DEAD -> P_ON/N_ON, with a dead interval of
// max(dead_time, 1) cycles after the last phase change before any side is
// driven. A fault latches and disarms the stage; enable must then be cycled
// low and high (after the latch is cleared) before the gates run again.
// All gate outputs are registered from the next-state value, so every
// transition is visible right after the edge that takes it.
module gate_drive_out #(
    parameter int CHANNELS = 2,
    parameter int DT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    gate_drive_out_if.slave bus
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_P_ON = 2'd2;
    localparam logic [1:0] ST_N_ON = 2'd3;

    logic [CHANNELS-1:0][1:0]          state_q;
    logic [CHANNELS-1:0][1:0]          state_d;
    logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_q;
    logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_d;
    logic [CHANNELS-1:0]               phase_q;
    logic [CHANNELS-1:0]               gate_p_d;
    logic [CHANNELS-1:0]               gate_n_d;
    logic [CHANNELS-1:0]               gate_p_q;
    logic [CHANNELS-1:0]               gate_n_q;
    logic                              active_q;
    logic                              armed_q;
    logic                              fault_q;
    logic                              shutdown;
    logic [DT_WIDTH-1:0]               dead_load;

    // A zero dead_time still yields one both-off cycle.
    always_comb begin
        dead_load = (bus.dead_time == '0) ? DT_WIDTH'(1) : bus.dead_time;
    end

    assign shutdown = bus.fault_in | ~bus.enable;

    // Per-channel next state and dead counter; shutdown overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gate_p_d = '0;
        gate_n_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (shutdown) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (armed_q && !fault_q) begin
                            state_d[i] = ST_DEAD;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    ST_DEAD: begin
                        if (bus.phase_in[i] != phase_q[i]) begin
                            // Phase moved: restart the whole interval.
                            cnt_d[i] = dead_load;
                        end else if (cnt_q[i] <= DT_WIDTH'(1)) begin
                            state_d[i] = bus.phase_in[i] ? ST_P_ON : ST_N_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    ST_P_ON: begin
                        if (!bus.phase_in[i]) begin
                            state_d[i] = ST_DEAD;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    ST_N_ON: begin
                        if (bus.phase_in[i]) begin
                            state_d[i] = ST_DEAD;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            gate_p_d[i] = (state_d[i] == ST_P_ON);
            gate_n_d[i] = (state_d[i] == ST_N_ON);
        end
    end

    // Channel state, counters, phase history and registered gate drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            gate_p_q <= '0;
            gate_n_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= bus.phase_in;
            gate_p_q <= gate_p_d;
            gate_n_q <= gate_n_d;
            active_q <= |(gate_p_d | gate_n_d);
        end
    end

    // Fault latch and arm flag; a fault request beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            armed_q <= 1'b0;
        end else if (bus.fault_in) begin
            fault_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            if (bus.fault_clear) begin
                fault_q <= 1'b0;
            end
            if (!bus.enable && !fault_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign bus.gate_p        = gate_p_q;
    assign bus.gate_n        = gate_n_q;
    assign bus.fault_latched = fault_q;
    assign bus.active        = active_q;
    assign bus.state_dbg     = state_q;
    assign bus.armed_dbg     = armed_q;

endmodule

// File: tb/tb_gate_drive_out.sv
// Bench for gate_drive_out: long dead-time, glitch and enable-drop sequences
// written by hand, short dead_time=0 and fault sequences from a vector table.
// Expected outputs are queued when an input set is driven and checked just
// after the edge that consumes it.
`timescale 1ns/1ps
module tb_gate_drive_out;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int EW = 6;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gate_drive_out_if #(.CHANNELS(CH), .DT_WIDTH(DW)) bus ();

  gate_drive_out #(.CHANNELS(CH), .DT_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  string name_q[$];

  typedef struct {
    logic        en;
    logic [1:0]  ph;
    logic [7:0]  dt;
    logic        fi;
    logic        fc;
    logic [1:0]  ep;
    logic [1:0]  en_exp;
    logic        ef;
    logic        ea;
  } vec_t;

  vec_t tbl[16];

  // driver tasks
  task automatic drive(input logic en, input logic [1:0] ph, input logic [7:0] dt,
                       input logic fi, input logic fc);
    bus.enable      = en;
    bus.phase_in    = ph;
    bus.dead_time   = dt;
    bus.fault_in    = fi;
    bus.fault_clear = fc;
  endtask

  task automatic compare(input logic [EW-1:0] exp_v, input string nm);
    logic [EW-1:0] got;
    got = {bus.gate_p, bus.gate_n, bus.fault_latched, bus.active};
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual p=%b n=%b flt=%b act=%b, expected p=%b n=%b flt=%b act=%b",
               nm, got[5:4], got[3:2], got[1], got[0],
               exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  // Queue the expectation for the current inputs, run one edge, score it.
  task automatic step(input logic [1:0] ep, input logic [1:0] enx,
                      input logic ef, input logic ea, input string nm);
    logic [EW-1:0] e;
    string s;
    exp_q.push_back({ep, enx, ef, ea});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    s = name_q.pop_front();
    compare(e, s);
  endtask

  // scoreboard side check: the two sides of a pair never overlap
  always @(negedge clk) begin
    if (!reset && ((bus.gate_p & bus.gate_n) != '0)) begin
      n_fail++;
      $display("FAIL overlap: actual p=%b n=%b, required no common bit", bus.gate_p, bus.gate_n);
    end
  end

  // time limit
  initial begin
    #2000000;
    $display("FAIL timeout: actual still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // dead_time=0 walk, both channels through P and N
    tbl[0]  = '{1'b1, 2'b11, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 8'd0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b1};
    // fault, fault+clear, no re-arm while latched, clear, re-arm, run
    tbl[6]  = '{1'b1, 2'b00, 8'd10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 8'd10, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 8'd10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 8'd10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 8'd10, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 8'd10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 8'd2,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 8'd2,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 8'd2,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 8'd2,  1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b1};

    drive(1'b0, 2'b00, 8'd0, 1'b0, 1'b0);
    #2;
    compare('0, "reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // dead time 16 from enable, then toggle channel 0
    drive(1'b0, 2'b01, 8'd16, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0, "arm");
    bus.enable = 1'b1;
    for (int i = 0; i < 16; i++) step(2'b00, 2'b00, 1'b0, 1'b0, "dt16_dead");
    step(2'b01, 2'b10, 1'b0, 1'b1, "dt16_on");
    bus.phase_in = 2'b00;
    for (int i = 0; i < 16; i++) step(2'b00, 2'b10, 1'b0, 1'b1, "dt16_fall");
    step(2'b00, 2'b11, 1'b0, 1'b1, "dt16_rise");

    // phase glitch inside a 10-cycle dead interval, dead_time moved mid-interval
    bus.dead_time = 8'd10;
    bus.phase_in = 2'b01;
    for (int i = 0; i < 4; i++) step(2'b00, 2'b10, 1'b0, 1'b1, "glitch_first");
    bus.phase_in = 2'b00;
    step(2'b00, 2'b10, 1'b0, 1'b1, "glitch_second");
    bus.dead_time = 8'd3;
    for (int i = 0; i < 9; i++) step(2'b00, 2'b10, 1'b0, 1'b1, "glitch_hold");
    step(2'b00, 2'b11, 1'b0, 1'b1, "glitch_rise");

    // table: dead_time=0 and fault sequences
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].ph, tbl[i].dt, tbl[i].fi, tbl[i].fc);
      step(tbl[i].ep, tbl[i].en_exp, tbl[i].ef, tbl[i].ea, $sformatf("vec%0d", i));
    end

    // one-cycle enable drop while running
    drive(1'b0, 2'b00, 8'd5, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0, "en_drop");
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 1'b0, 1'b0, "reen_dead");
    step(2'b00, 2'b11, 1'b0, 1'b1, "reen_on");

    // asynchronous reset with gates on, no edge in between
    reset = 1'b1;
    #2;
    compare('0, "async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2'b00, 2'b00, 1'b0, 1'b0, "post_reset_unarmed");

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: actual %0d left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
